// File: rtl/rand_word_collector.sv
`default_nettype none
// ============================================================================
// Module   : rand_word_collector
// Purpose  : Consumer end of the differential-privacy random-bit stream.
//            Packs WIDTH accepted random bits (first bit in the MSB) into a word
//            and offers it to the noise sampler over valid/ready. There is one
//            shift register and one output register. Bits that arrive while a
//            completed word has nowhere to go are dropped and counted.
// Ports    : clk          in   system clock, rising edge
//            rst_n        in   asynchronous active-low reset
//            bit_in       in   random bit from the generator
//            bit_valid    in   bit_in is meaningful this cycle
//            word_out     out  [WIDTH-1:0] packed random word
//            word_valid   out  word_out holds an unconsumed word
//            word_ready   in   consumer accepts (transfer on valid & ready)
//            overflow     out  sticky, set on the first dropped bit
//            drop_cnt     out  [DROP_W-1:0] saturating dropped-bit count
//            health_fail  out  sticky repetition-count-test failure
// Options  : define RCT_EN to build the repetition-count health test
//            (cutoff RCT_LIMIT). Without it health_fail is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module rand_word_collector #(
  parameter int WIDTH     = 24,
  parameter int DROP_W    = 16,
  parameter int RCT_LIMIT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [WIDTH-1:0]  word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              health_fail
);

  localparam int c_CNT_W = $clog2(WIDTH + 1);

  // Elaboration-time guard on the supported parameter ranges.
  generate
    if (WIDTH < 2 || WIDTH > 32 || DROP_W < 1 || RCT_LIMIT < 2) begin : g_param_check
      $error("rand_word_collector: unsupported parameter value");
    end
  endgenerate

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [WIDTH-1:0]    r_shift;
  logic [WIDTH-1:0]    w_shift_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [c_CNT_W-1:0]  w_cnt_nxt;
  logic [WIDTH-1:0]    r_word;
  logic [WIDTH-1:0]    w_word_nxt;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_overflow;
  logic                w_overflow_nxt;
  logic [DROP_W-1:0]   r_drop;
  logic [DROP_W-1:0]   w_drop_nxt;

  logic                w_xfer;
  logic                w_out_free;
  logic                w_accept;
  logic                w_full;
  logic [WIDTH-1:0]    w_shifted;
  logic                w_health_trip;   // this accepted bit fails the health test
  logic                w_health_block;  // health test already failed: load nothing

  assign w_xfer     = r_valid & word_ready;
  // The output register can take a new word this edge if it is empty or its
  // current word is being consumed on the same edge.
  assign w_out_free = ~r_valid | word_ready;
  assign w_accept   = bit_valid & (r_state == S_FILL);
  assign w_shifted  = {r_shift[WIDTH-2:0], bit_in};
  assign w_full     = (r_cnt == c_CNT_W'(WIDTH - 1));

`ifdef RCT_EN
  localparam int c_RUN_W = $clog2(RCT_LIMIT + 1);

  logic [c_RUN_W-1:0] r_run;
  logic [c_RUN_W-1:0] w_run_nxt;
  logic               r_last_bit;
  logic               r_health;

  // Run length including the current bit; a zero run means no history yet.
  always_comb begin
    w_run_nxt = c_RUN_W'(1);
    if (r_run != '0 && bit_in == r_last_bit) begin
      if (r_run == c_RUN_W'(RCT_LIMIT)) begin
        w_run_nxt = r_run;
      end else begin
        w_run_nxt = r_run + c_RUN_W'(1);
      end
    end
  end

  assign w_health_trip  = w_accept & ~r_health & (w_run_nxt == c_RUN_W'(RCT_LIMIT));
  assign w_health_block = r_health;
  assign health_fail    = r_health;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= '0;
      r_last_bit <= 1'b0;
      r_health   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_run      <= w_run_nxt;
        r_last_bit <= bit_in;
      end
      if (w_health_trip) begin
        r_health <= 1'b1;
      end
    end
  end
`else
  assign w_health_trip  = 1'b0;
  assign w_health_block = 1'b0;
  assign health_fail    = 1'b0;
`endif

  // Next-state and datapath control.
  always_comb begin
    w_state_nxt    = r_state;
    w_shift_nxt    = r_shift;
    w_cnt_nxt      = r_cnt;
    w_word_nxt     = r_word;
    w_valid_nxt    = r_valid;
    w_overflow_nxt = r_overflow;
    w_drop_nxt     = r_drop;

    if (w_xfer) begin
      w_valid_nxt = 1'b0;
    end

    case (r_state)
      S_FILL: begin
        if (w_accept) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
          if (w_health_trip) begin
            // Failing bit discards the partial word, even if it completes one.
            w_cnt_nxt = '0;
          end else if (w_full) begin
            w_cnt_nxt = '0;
            if (w_health_block) begin
              // Word is discarded while the health test is failed.
            end else if (w_out_free) begin
              w_word_nxt  = w_shifted;
              w_valid_nxt = 1'b1;
            end else begin
              // Keep the full word in the shift register until space opens.
              w_state_nxt = S_HOLD;
            end
          end
        end
      end

      S_HOLD: begin
        if (bit_valid) begin
          w_overflow_nxt = 1'b1;
          if (r_drop != {DROP_W{1'b1}}) begin
            w_drop_nxt = r_drop + DROP_W'(1);
          end
        end
        if (w_xfer) begin
          w_word_nxt  = r_shift;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_FILL;
        end
      end

      default: begin
        w_state_nxt = S_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FILL;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_word     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_shift    <= w_shift_nxt;
      r_cnt      <= w_cnt_nxt;
      r_word     <= w_word_nxt;
      r_valid    <= w_valid_nxt;
      r_overflow <= w_overflow_nxt;
      r_drop     <= w_drop_nxt;
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_valid;
  assign overflow   = r_overflow;
  assign drop_cnt   = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_rand_word_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_word_collector
// Purpose  : Scoreboard bench for rand_word_collector (WIDTH=8, DROP_W=4).
//            Stimulus pushes expected words; a monitor pops them on each
//            valid & ready transfer and checks hold stability.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_word_collector;

  localparam int WIDTH     = 8;
  localparam int DROP_W    = 4;
  localparam int RCT_LIMIT = 32;

  logic              clk;
  logic              rst_n;
  logic              bit_in;
  logic              bit_valid;
  logic [WIDTH-1:0]  word_out;
  logic              word_valid;
  logic              word_ready;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              health_fail;

  rand_word_collector #(
    .WIDTH     (WIDTH),
    .DROP_W    (DROP_W),
    .RCT_LIMIT (RCT_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_in      (bit_in),
    .bit_valid   (bit_valid),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .overflow    (overflow),
    .drop_cnt    (drop_cnt),
    .health_fail (health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0] exp_q[$];
  int               pop_cyc[$];
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_word  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer; checks hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(word_valid), 32'd1);
        check("hold_stable", 32'(word_out), 32'(prev_word));
      end
      if (word_valid && word_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", word_out);
        end else begin
          check("word", 32'(word_out), 32'(exp_q.pop_front()));
          pop_cyc.push_back(cyc);
        end
      end
      prev_stall = word_valid && !word_ready;
      prev_word  = word_out;
    end
  end

  task automatic send_bit(input logic b);
    bit_in    = b;
    bit_valid = 1'b1;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_alt(input int n);
    for (int i = 0; i < n; i++) send_bit(i[0]);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    #12;
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_health", 32'(health_fail), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: 1,0,1,1,0,0,1,0 -> B2, valid for exactly one cycle.
    word_ready = 1'b1;
    exp_q.push_back(8'hB2);
    send_word(8'hB2);
    @(negedge clk);
    check("t1_valid_after_8th", 32'(word_valid), 32'd1);
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(word_valid), 32'd0);
    idle(1);

    // Test 2: continuous stream, one word every 8 cycles.
    pop_cyc.delete();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h96);
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'h96);
    idle(2);
    check("t2_word_count", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("t2_spacing_a", 32'(pop_cyc[1] - pop_cyc[0]), 32'd8);
      check("t2_spacing_b", 32'(pop_cyc[2] - pop_cyc[1]), 32'd8);
    end
    check("t2_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t2_overflow", 32'(overflow), 32'd0);

    // Test 3: back-pressure for 30 bits; second word waits in HOLD.
    word_ready = 1'b0;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send_word(8'h12);
    send_word(8'h34);
    send_alt(14);
    check("t3_drop_cnt", 32'(drop_cnt), 32'd14);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_held_word", 32'(word_out), 32'h12);
    word_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t3_no_gap", 32'(word_valid), 32'd1);
    check("t3_second_word", 32'(word_out), 32'h34);
    idle(2);
    check("t3_drop_final", 32'(drop_cnt), 32'd14);

    // Test 4: 40 bits under back-pressure saturate the 4-bit counter.
    do_reset();
    word_ready = 1'b0;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h0F);
    send_word(8'h5A);
    send_word(8'h0F);
    send_alt(24);
    check("t4_drop_sat", 32'(drop_cnt), 32'hF);
    check("t4_overflow", 32'(overflow), 32'd1);
    word_ready = 1'b1;
    idle(3);

    // Test 5: asynchronous reset after 5 bits, then a clean word.
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_word_out", 32'(word_out), 32'd0);
    check("t5_word_valid", 32'(word_valid), 32'd0);
    check("t5_overflow", 32'(overflow), 32'd0);
    check("t5_drop_cnt", 32'(drop_cnt), 32'd0);
    check("t5_health", 32'(health_fail), 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'hC3);
    send_word(8'hC3);
    idle(2);

    // Test 6: 32 consecutive ones.
    do_reset();
    word_ready = 1'b1;
`ifdef RCT_EN
    repeat (3) exp_q.push_back(8'hFF);
    send_word(8'hFF);
    send_word(8'hFF);
    send_word(8'hFF);
    send_word(8'hFF);
    idle(1);
    check("t6_health_fail", 32'(health_fail), 32'd1);
    send_word(8'hFF);
    send_word(8'h5A);
    idle(2);
    check("t6_no_word", 32'(word_valid), 32'd0);
    check("t6_health_sticky", 32'(health_fail), 32'd1);
`else
    repeat (6) exp_q.push_back(8'hFF);
    repeat (6) send_word(8'hFF);
    idle(2);
    check("t6_health_zero", 32'(health_fail), 32'd0);
`endif

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
